// File: rtl/tm1638_pkg.sv
// Shared types and command constants for the TM1638 serial responder.
//   state_t         : responder frame state
//   CMD_*           : TM1638 command bytes as seen on the link
package tm1638_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam logic [7:0] CMD_WRITE_AUTO  = 8'h40;
    localparam logic [7:0] CMD_READ_KEYS   = 8'h42;
    localparam logic [7:0] CMD_WRITE_FIXED = 8'h44;
    localparam logic [7:0] CMD_ADDR_BASE   = 8'hC0;
    localparam logic [7:0] CMD_DISP_BASE   = 8'h80;

endpackage

// File: rtl/spi_sync_edge.sv
// Input synchroniser with a trailing edge register.
//   i_Clk, i_Rst : system clock, synchronous active-low reset
//   i_Pin        : asynchronous pin
//   o_Level      : synchronised level
//   o_Rise_c     : one-cycle pulse on synchronised rising edge
//   o_Fall_c     : one-cycle pulse on synchronised falling edge
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Pin,
    output logic o_Level,
    output logic o_Rise_c,
    output logic o_Fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift chain; stage SYNC_STAGES-1 is the settled level.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_Pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_Level  = r_sync[SYNC_STAGES-1];
    assign o_Rise_c =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_Fall_c = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/tm1638_spi_responder.sv
// Device end of the TM1638 STB/CLK/DIO link: receives LSB-first bytes,
// flags the command byte, and answers the read command with key data.
//   i_Clk, i_Rst          : system clock, synchronous active-low reset
//   i_SPI_Stb, i_SPI_Clk  : frame strobe (active-low), serial clock
//   io_SPI_Dio            : bidirectional serial data
//   i_Key_Data            : read payload, byte 0 in [7:0] sent first
//   o_Byte_Valid/o_Byte   : received byte pulse / held byte
//   o_Byte_Cmd            : pulse qualifier, byte is the frame's first
//   o_Frame_End/_Err      : end-of-frame pulse / truncated frame flag
//   o_Read_Busy           : DIO is being driven
module tm1638_spi_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  READ_CMD    = CMD_READ_KEYS,
    parameter int unsigned READ_BYTES  = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_SPI_Stb,
    input  logic                    i_SPI_Clk,
    inout  wire                     io_SPI_Dio,
    input  logic [8*READ_BYTES-1:0] i_Key_Data,
    output logic                    o_Byte_Valid,
    output logic [7:0]              o_Byte,
    output logic                    o_Byte_Cmd,
    output logic                    o_Frame_End,
    output logic                    o_Frame_Err,
    output logic                    o_Read_Busy
);

    localparam int unsigned RD_BITS = 8 * READ_BYTES;
    localparam int unsigned RCW     = $clog2(RD_BITS + 1);
    localparam logic [RCW-1:0] RD_LAST = RCW'(RD_BITS);

    logic w_stb_lvl, w_stb_rise, w_stb_fall;
    logic w_clk_lvl, w_clk_rise, w_clk_fall;
    logic w_dio_lvl, w_dio_rise, w_dio_fall;
    logic w_unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_stb (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Pin(i_SPI_Stb),
        .o_Level(w_stb_lvl), .o_Rise_c(w_stb_rise), .o_Fall_c(w_stb_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Pin(i_SPI_Clk),
        .o_Level(w_clk_lvl), .o_Rise_c(w_clk_rise), .o_Fall_c(w_clk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_dio (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Pin(io_SPI_Dio),
        .o_Level(w_dio_lvl), .o_Rise_c(w_dio_rise), .o_Fall_c(w_dio_fall));

    assign w_unused_edges = &{1'b0, w_stb_lvl, w_clk_lvl, w_dio_rise, w_dio_fall};

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [RD_BITS-1:0]   r_rd_shift, w_rd_shift_nxt;
    logic [RCW-1:0]       r_rd_cnt, w_rd_cnt_nxt;
    logic                 r_rd_done, w_rd_done_nxt;
    logic                 r_oe, w_oe_nxt;
    logic                 r_dio_q, w_dio_q_nxt;
    logic                 r_byte_valid, w_byte_valid_nxt;
    logic [7:0]           r_byte, w_byte_nxt;
    logic                 r_byte_cmd, w_byte_cmd_nxt;
    logic                 r_frame_end, w_frame_end_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic [7:0]           w_shift_in;
    logic                 w_byte_done;

    assign w_shift_in  = {w_dio_lvl, r_shift[7:1]};
    assign w_byte_done = w_clk_rise && (r_bit_cnt == 3'd7);

    // State register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; a strobe rise always wins over a coincident clock edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_stb_fall) w_state_nxt = CMD;
            CMD: begin
                if (w_stb_rise)       w_state_nxt = IDLE;
                else if (w_byte_done) w_state_nxt = (w_shift_in == READ_CMD) ? READ : WDATA;
            end
            WDATA: if (w_stb_rise) w_state_nxt = IDLE;
            READ: begin
                if (w_stb_rise)                             w_state_nxt = IDLE;
                else if (w_clk_fall && r_rd_cnt == RD_LAST) w_state_nxt = WDATA;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_rd_shift_nxt   = r_rd_shift;
        w_rd_cnt_nxt     = r_rd_cnt;
        w_rd_done_nxt    = r_rd_done;
        w_oe_nxt         = r_oe;
        w_dio_q_nxt      = r_dio_q;
        w_byte_valid_nxt = 1'b0;
        w_byte_nxt       = r_byte;
        w_byte_cmd_nxt   = 1'b0;
        w_frame_end_nxt  = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_stb_fall) begin
                    w_shift_nxt   = 8'h00;
                    w_bit_cnt_nxt = 3'd0;
                    w_rd_done_nxt = 1'b0;
                end
            end
            CMD, WDATA: begin
                if (w_stb_rise) begin
                    w_frame_end_nxt = 1'b1;
                    w_frame_err_nxt = (r_bit_cnt != 3'd0);
                end else if (w_clk_rise && !r_rd_done) begin
                    // Bits after a completed read are ignored until the frame ends.
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_valid_nxt = 1'b1;
                        w_byte_nxt       = w_shift_in;
                        w_byte_cmd_nxt   = (r_state == CMD);
                        if (r_state == CMD && w_shift_in == READ_CMD) begin
                            w_rd_shift_nxt = i_Key_Data;
                            w_rd_cnt_nxt   = '0;
                            w_oe_nxt       = 1'b1;
                            w_dio_q_nxt    = i_Key_Data[0];
                        end
                    end
                end
            end
            READ: begin
                if (w_stb_rise) begin
                    w_oe_nxt        = 1'b0;
                    w_frame_end_nxt = 1'b1;
                    w_frame_err_nxt = (r_bit_cnt != 3'd0) || (r_rd_cnt != RD_LAST);
                end else if (w_clk_rise) begin
                    if (r_rd_cnt != RD_LAST) w_rd_cnt_nxt = r_rd_cnt + RCW'(1);
                end else if (w_clk_fall) begin
                    // The fall right after the command byte keeps bit 0 on the line.
                    if (r_rd_cnt == RD_LAST) begin
                        w_oe_nxt      = 1'b0;
                        w_rd_done_nxt = 1'b1;
                    end else if (r_rd_cnt != '0) begin
                        w_rd_shift_nxt = r_rd_shift >> 1;
                        w_dio_q_nxt    = r_rd_shift[1];
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_rd_shift   <= '0;
            r_rd_cnt     <= '0;
            r_rd_done    <= 1'b0;
            r_oe         <= 1'b0;
            r_dio_q      <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'h00;
            r_byte_cmd   <= 1'b0;
            r_frame_end  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_rd_shift   <= w_rd_shift_nxt;
            r_rd_cnt     <= w_rd_cnt_nxt;
            r_rd_done    <= w_rd_done_nxt;
            r_oe         <= w_oe_nxt;
            r_dio_q      <= w_dio_q_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_byte       <= w_byte_nxt;
            r_byte_cmd   <= w_byte_cmd_nxt;
            r_frame_end  <= w_frame_end_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    assign io_SPI_Dio   = r_oe ? r_dio_q : 1'bz;
    assign o_Byte_Valid = r_byte_valid;
    assign o_Byte       = r_byte;
    assign o_Byte_Cmd   = r_byte_cmd;
    assign o_Frame_End  = r_frame_end;
    assign o_Frame_Err  = r_frame_err;
    assign o_Read_Busy  = r_oe;

endmodule

// File: tb/tb_tm1638_spi_responder.sv
// Bench for tm1638_spi_responder: a behavioural TM1638 master drives frames,
// a scoreboard holds expected bytes / frame-end flags, a monitor checks them.
module tb_tm1638_spi_responder;

    localparam int unsigned RB = 4;
    localparam int unsigned H  = 6;
    localparam logic [7:0]  RD_CMD = 8'h42;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             m_stb, m_clk, m_oe, m_dio;
    logic [8*RB-1:0]  key_data;
    logic             o_Byte_Valid, o_Byte_Cmd, o_Frame_End, o_Frame_Err, o_Read_Busy;
    logic [7:0]       o_Byte;
    wire              w_dio;

    pullup (w_dio);
    assign w_dio = m_oe ? m_dio : 1'bz;

    always #5 clk = ~clk;

    tm1638_spi_responder #(.SYNC_STAGES(2), .READ_CMD(RD_CMD), .READ_BYTES(RB)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_SPI_Stb(m_stb), .i_SPI_Clk(m_clk),
        .io_SPI_Dio(w_dio), .i_Key_Data(key_data),
        .o_Byte_Valid(o_Byte_Valid), .o_Byte(o_Byte), .o_Byte_Cmd(o_Byte_Cmd),
        .o_Frame_End(o_Frame_End), .o_Frame_Err(o_Frame_Err), .o_Read_Busy(o_Read_Busy));

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp_byte_q[$];   // {cmd, byte}
    logic       exp_err_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT pulse pops and checks the next expectation.
    always @(negedge clk) begin
        if (rst_n && o_Byte_Valid) begin
            if (exp_byte_q.size() == 0) check("unexpected_byte", {o_Byte_Cmd, o_Byte}, 64'hDEAD);
            else check("byte", {o_Byte_Cmd, o_Byte}, exp_byte_q.pop_front());
        end
        if (rst_n && o_Frame_End) begin
            if (exp_err_q.size() == 0) check("unexpected_frame_end", o_Frame_Err, 64'hDEAD);
            else check("frame_err", o_Frame_Err, exp_err_q.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        m_stb = 1'b0;
        wait_cyc(H);
    endtask

    task automatic end_frame();
        m_oe  = 1'b0;
        m_stb = 1'b1;
        wait_cyc(3);
        check("busy_after_stb", o_Read_Busy, 0);
        wait_cyc(3 * H);
    endtask

    // Master drives DIO from the clock fall until one cycle past the rise.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_clk = 1'b0; m_oe = 1'b1; m_dio = b[i];
            wait_cyc(H);
            m_clk = 1'b1;
            wait_cyc(1);
            m_oe = 1'b0;
            wait_cyc(H - 1);
        end
    endtask

    task automatic read_bits(input logic [7:0] kb[RB], input int n);
        for (int i = 0; i < n; i++) begin
            m_clk = 1'b0;
            wait_cyc(H);
            m_clk = 1'b1;
            check($sformatf("rd_bit%0d", i), w_dio, kb[i / 8][i % 8]);
            check("rd_busy", o_Read_Busy, 1);
            wait_cyc(H);
        end
    endtask

    task automatic set_key(input logic [7:0] kb[RB]);
        for (int i = 0; i < RB; i++) key_data[8*i +: 8] = kb[i];
    endtask

    // Write frame: full bytes then an optional partial byte of pbits bits.
    task automatic do_write(input logic [7:0] bq[$], input int pbits, input logic [7:0] pbyte);
        for (int i = 0; i < bq.size(); i++) exp_byte_q.push_back({(i == 0), bq[i]});
        exp_err_q.push_back(pbits != 0);
        start_frame();
        for (int i = 0; i < bq.size(); i++) send_bits(bq[i], 8);
        if (pbits != 0) send_bits(pbyte, pbits);
        end_frame();
    endtask

    // Read frame: n read bits; n == 8*RB completes with the releasing fall.
    task automatic do_read(input logic [7:0] kb[RB], input int n);
        set_key(kb);
        exp_byte_q.push_back({1'b1, RD_CMD});
        exp_err_q.push_back(n != 8 * RB);
        start_frame();
        send_bits(RD_CMD, 8);
        read_bits(kb, n);
        if (n == 8 * RB) begin
            m_clk = 1'b0;
            wait_cyc(H);
            check("busy_after_last_fall", o_Read_Busy, 0);
            check("dio_released", w_dio, 1);
            m_clk = 1'b1;
            wait_cyc(H);
        end
        end_frame();
    endtask

    logic [7:0] bq[$];
    logic [7:0] kb[RB];

    initial begin
        rst_n = 1'b0; m_stb = 1'b1; m_clk = 1'b1; m_oe = 1'b0; m_dio = 1'b0;
        key_data = '0;
        wait_cyc(5);
        check("reset_outs", {o_Byte_Valid, o_Byte, o_Byte_Cmd, o_Frame_End, o_Frame_Err, o_Read_Busy}, 0);
        check("reset_dio", w_dio, 1);
        rst_n = 1'b1;
        wait_cyc(5);

        // T1: single command byte.
        bq = {8'h40};
        do_write(bq, 0, 8'h00);
        check("t1_byte_held", o_Byte, 8'h40);

        // T2: command plus data bytes.
        bq = {8'hC0, 8'h01, 8'h02, 8'h80};
        do_write(bq, 0, 8'h00);

        // T3: full key read.
        kb = '{8'h81, 8'h0F, 8'h3C, 8'hA5};
        do_read(kb, 32);

        // T4: cut after 5 bits, then a clean frame.
        bq = {};
        do_write(bq, 5, 8'h5B);
        bq = {8'h44};
        do_write(bq, 0, 8'h00);

        // T5: read cut after 12 bits.
        kb = '{8'h81, 8'h0F, 8'h3C, 8'hA5};
        do_read(kb, 12);

        // T6: reset mid-read, then a fresh read.
        kb = '{8'h00, 8'h00, 8'h5A, 8'h5A};
        set_key(kb);
        exp_byte_q.push_back({1'b1, RD_CMD});
        start_frame();
        send_bits(RD_CMD, 8);
        read_bits(kb, 10);
        check("t6_dio_driven_low", w_dio, 0);
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        m_stb = 1'b1;
        check("t6_rst_outs", {o_Byte_Valid, o_Byte, o_Byte_Cmd, o_Frame_End, o_Frame_Err, o_Read_Busy}, 0);
        check("t6_rst_dio", w_dio, 1);
        wait_cyc(3 * H);
        for (int i = 0; i < RB; i++) kb[i] = 8'($urandom);
        do_read(kb, 32);

        // Randomised frames.
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 2) != 2) begin
                bq = {};
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) bq.push_back(8'($urandom));
                if (bq[0] == RD_CMD) bq[0] = 8'h43;
                if ($urandom_range(0, 3) == 0) do_write(bq, int'($urandom_range(1, 7)), 8'($urandom));
                else do_write(bq, 0, 8'h00);
            end else begin
                for (int i = 0; i < RB; i++) kb[i] = 8'($urandom);
                if ($urandom_range(0, 1) == 1) do_read(kb, 32);
                else do_read(kb, int'($urandom_range(1, 31)));
            end
        end

        wait_cyc(10);
        check("sb_bytes_left", exp_byte_q.size(), 0);
        check("sb_frames_left", exp_err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
